ld_to_affine: RTL and testbench
===============================

Name: ld_to_affine

Overview:
- Sequential converter from López-Dahab projective coordinates (X,Y,Z) to affine (x,y) over GF(2^N): x = X/Z, y = Y/Z^2.
- Sits directly downstream of the point-add/point-double datapath and consumes each registered multiple k*P as it is produced.
- Computes Z^-1 by Fermat exponentiation (Z^(2^N-2)) with one field multiplier, issuing one multiplication per cycle.
- Valid/ready handshake on both sides.

Parameters:
- N, 3, field width in bits.
- POLY, 4'b1011, irreducible reduction polynomial, N+1 bits (x^3+x+1); MSB must be 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input point present.
- in_ready  out  1  block can accept a point; high only in IDLE.
- in_x  in  N  projective X.
- in_y  in  N  projective Y.
- in_z  in  N  projective Z.
- out_valid  out  1  affine result present.
- out_ready  in  1  consumer accepts result.
- out_x  out  N  affine x.
- out_y  out  N  affine y.
- out_inf  out  1  input was the point at infinity (Z==0).

Behaviour:
- Reset (async, rst=1): state=IDLE, out_valid=0, out_x=0, out_y=0, out_inf=0, all internal registers 0. While in reset in_ready=0; it is 1 from the first cycle after rst falls.
- Reset mid-conversion aborts the point with no output; the in-flight point is lost.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch X, Y and Z, set r=Z, set inf=(Z==0), load counter=N-2, and go to INV_SQ, or to INV_FIN if N-2==0.
  - INV_SQ: r <= r*r, then go to INV_MUL.
  - INV_MUL: r <= r*Z. Decrement counter. When counter reaches 0, go to INV_FIN; otherwise go to INV_SQ.
  - INV_FIN: r <= r*r, so r = Z^(2^N-2) = Z^-1. Go to MX.
  - MX: out_x <= X*r. Go to SQ.
  - SQ: r <= r*r (Z^-2). Go to MY.
  - MY: out_y <= Y*r, out_inf <= inf, out_valid <= 1. Go to DONE.
  - DONE: hold all outputs stable while out_ready=0. On out_ready=1: out_valid <= 0, then go to IDLE.
- Latency: exactly 2N multiply cycles (6 for N=3). out_valid rises on the 2N-th rising edge after the accepting edge.
- Throughput: one point per 2N+2 cycles with out_ready tied high. in_ready is 0 from the cycle after acceptance until the cycle after the output handshake.
- Inputs are sampled only at acceptance. Changes on in_* outside IDLE are ignored.
- Arithmetic:
  - Addition is XOR.
  - Multiplication is the polynomial product reduced mod POLY; result is N bits, no carries.
  - Squaring uses the same multiplier with both operands equal to r.
- Z==0: no special path. The exponentiation yields 0, so out_x=out_y=0 and out_inf=1, with the same latency.
- Z==1: the result must equal (X,Y) exactly.
- Multiplier operand muxing:
  - Operand a = r, X or Y.
  - Operand b = r or Z.
  - Both are selected by state only.

Decomposition:
- Shared package holds: N, POLY, the state encoding (IDLE, INV_SQ, INV_MUL, INV_FIN, MX, SQ, MY, DONE), and the counter width clog2(N).
- One sub-module: gf2m_mul, a combinational N-bit GF(2^N) multiplier parameterised by N and POLY. The same sub-module is reused by the point-add and point-double datapath.

Test Plan:
- Affine passthrough: (X,Y,Z)=(110,001,001) -> (out_x,out_y,out_inf)=(110,001,0), 6 cycles after acceptance.
- General point: (110,011,010) -> Z^-1=101, Z^-2=111, out=(011,010,0).
- Infinity: (101,011,000) -> out=(000,000,1), same 6-cycle latency.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0, a pulsed in_valid is ignored. With out_ready=1 -> handshake; in_ready=1 the next cycle.
- Reset mid-op: assert rst 3 cycles after acceptance -> out_valid, out_x, out_y and out_inf are 0 immediately, no result is emitted, in_ready=1 the cycle after rst deasserts.
- Stream of k*P: feed all 7 nonzero Z values with X=110, Y=001 and out_ready=1 -> each result matches a software GF(2^3) model, with acceptances spaced 8 cycles apart.

Source files
------------

// File: rtl/ld_to_affine_pkg.sv
// rtl/ld_to_affine_pkg.sv - shared field constants and FSM encoding for the LD-to-affine converter
package ld_to_affine_pkg;

  // Field GF(2^N) with reduction polynomial x^3+x+1
  localparam int N = 3;
  localparam logic [N:0] POLY = 4'b1011;

  // Loop counter holds N-2 square-and-multiply iterations
  localparam int CNT_W = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INV_SQ,
    ST_INV_MUL,
    ST_INV_FIN,
    ST_MX,
    ST_SQ,
    ST_MY,
    ST_DONE
  } state_t;

endpackage

// File: rtl/ld_to_affine_gf2m_mul.sv
// rtl/ld_to_affine_gf2m_mul.sv - combinational GF(2^N) multiplier, MSB-first shift-and-add
module gf2m_mul #(
  parameter int         N    = 3,
  parameter logic [N:0] POLY = 4'b1011
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] p_o
);

  logic [N-1:0] acc;

  // Horner evaluation: multiply accumulator by x (reducing on overflow), then add a where b has a 1
  always_comb begin
    acc = '0;
    for (int i = N - 1; i >= 0; i--) begin
      acc = {acc[N-2:0], 1'b0} ^ (acc[N-1] ? POLY[N-1:0] : '0);
      if (b_i[i]) begin
        acc = acc ^ a_i;
      end
    end
  end

  assign p_o = acc;

endmodule

// File: rtl/ld_to_affine.sv
// rtl/ld_to_affine.sv - converts López-Dahab (X,Y,Z) to affine (X/Z, Y/Z^2) via Fermat inversion
module ld_to_affine
  import ld_to_affine_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_x,
  input  logic [N-1:0] in_y,
  input  logic [N-1:0] in_z,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_x,
  output logic [N-1:0] out_y,
  output logic         out_inf
);

  state_t          state_q;
  logic [N-1:0]    x_q, y_q, z_q, r_q;
  logic            inf_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N-1:0]    out_x_q, out_y_q;
  logic            out_inf_q, out_valid_q;

  logic [N-1:0]    mul_a, mul_b, mul_p;

  // Operand selection depends on state alone: a from {r, X, Y}, b from {r, Z}
  always_comb begin
    mul_a = r_q;
    mul_b = r_q;
    case (state_q)
      ST_INV_MUL: mul_b = z_q;
      ST_MX:      mul_a = x_q;
      ST_MY:      mul_a = y_q;
      default: begin
        mul_a = r_q;
        mul_b = r_q;
      end
    endcase
  end

  gf2m_mul #(.N(N), .POLY(POLY)) u_mul (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (mul_p)
  );

  // Conversion sequencer: one multiply per cycle, result held until the consumer takes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      r_q         <= '0;
      inf_q       <= 1'b0;
      cnt_q       <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_inf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            x_q     <= in_x;
            y_q     <= in_y;
            z_q     <= in_z;
            r_q     <= in_z;
            inf_q   <= (in_z == '0);
            cnt_q   <= CNT_W'(N - 2);
            state_q <= (N == 2) ? ST_INV_FIN : ST_INV_SQ;
          end
        end
        ST_INV_SQ: begin
          r_q     <= mul_p;
          state_q <= ST_INV_MUL;
        end
        ST_INV_MUL: begin
          r_q     <= mul_p;
          cnt_q   <= cnt_q - 1'b1;
          state_q <= (cnt_q == CNT_W'(1)) ? ST_INV_FIN : ST_INV_SQ;
        end
        ST_INV_FIN: begin
          // r now holds Z^(2^N-2), the inverse (or 0 for Z==0)
          r_q     <= mul_p;
          state_q <= ST_MX;
        end
        ST_MX: begin
          out_x_q <= mul_p;
          state_q <= ST_SQ;
        end
        ST_SQ: begin
          r_q     <= mul_p;
          state_q <= ST_MY;
        end
        ST_MY: begin
          out_y_q     <= mul_p;
          out_inf_q   <= inf_q;
          out_valid_q <= 1'b1;
          state_q     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign out_inf   = out_inf_q;

endmodule

// File: tb/tb_ld_to_affine.sv
// tb/tb_ld_to_affine.sv - randomized and directed self-checking bench for ld_to_affine
module tb_ld_to_affine;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, out_inf;
  logic [N-1:0] in_x, in_y, in_z, out_x, out_y;

  always #5 clk = ~clk;

  ld_to_affine dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_z      (in_z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_inf   (out_inf)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference field arithmetic: full polynomial product, then long division by x^3+x+1
  function automatic logic [N-1:0] m_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-2:0] p;
    logic [2*N-2:0] poly_w;
    p = '0;
    poly_w = 5'b01011;
    for (int i = 0; i < N; i++)
      if (b[i]) p = p ^ ((2*N-1)'(a) << i);
    for (int k = 2*N-2; k >= N; k--)
      if (p[k]) p = p ^ (poly_w << (k - N));
    return p[N-1:0];
  endfunction

  // Inverse by exhaustive search; 0 has no inverse and maps to 0
  function automatic logic [N-1:0] m_inv(input logic [N-1:0] z);
    for (int r = 1; r < (1 << N); r++)
      if (m_mul(z, N'(r)) == N'(1)) return N'(r);
    return '0;
  endfunction

  typedef struct {
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         inf;
    int           acc_cyc;
  } exp_t;

  exp_t q[$];

  // Scoreboard push on every accepted point
  always @(posedge clk) begin
    if (!rst && in_valid && in_ready) begin
      exp_t e;
      logic [N-1:0] zi;
      zi = m_inv(in_z);
      e.x = m_mul(in_x, zi);
      e.y = m_mul(in_y, m_mul(zi, zi));
      e.inf = (in_z == '0);
      e.acc_cyc = cyc + 1;
      q.push_back(e);
    end
  end

  logic         prev_valid = 1'b0, prev_ready = 1'b0, prev_inf = 1'b0;
  logic [N-1:0] prev_x = '0, prev_y = '0;

  // Compare process: latency, hold-stability, in_ready exclusion and result values
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (q.size() == 0) check("unexpected_output", 1, 0);
        else check("latency", cyc - q[0].acc_cyc, 2 * N);
      end
      if (out_valid && prev_valid && !prev_ready) begin
        check("hold_x", out_x, prev_x);
        check("hold_y", out_y, prev_y);
        check("hold_inf", out_inf, prev_inf);
      end
      if (out_valid) check("in_ready_while_valid", in_ready, 0);
      if (out_valid && out_ready && q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        check("out_x", out_x, e.x);
        check("out_y", out_y, e.y);
        check("out_inf", out_inf, e.inf);
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_x = out_x;
      prev_y = out_y;
      prev_inf = out_inf;
    end
  end

  int acc_at;

  task automatic send(input logic [N-1:0] x, input logic [N-1:0] y, input logic [N-1:0] z);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("send_timeout", 0, 1);
    in_x = x; in_y = y; in_z = z;
    in_valid = 1'b1;
    @(posedge clk); #1;
    acc_at = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) check("out_timeout", 0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", q.size(), 0);
  endtask

  logic rand_done;

  initial begin
    int last_acc;
    rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_z = '0; out_ready = 1'b0;

    // Reference model pinned to hand-computed values
    check("model_inv_010", m_inv(3'b010), 3'b101);
    check("model_inv2_010", m_mul(m_inv(3'b010), m_inv(3'b010)), 3'b111);
    check("model_mul_110_101", m_mul(3'b110, 3'b101), 3'b011);

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_x", out_x, 0);
    check("rst_out_y", out_y, 0);
    check("rst_out_inf", out_inf, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready, 1);

    // Affine passthrough
    out_ready = 1'b1;
    send(3'b110, 3'b001, 3'b001);
    wait_out();
    check("pass_cycles", cyc - acc_at, 6);
    check("pass_x", out_x, 3'b110);
    check("pass_y", out_y, 3'b001);
    check("pass_inf", out_inf, 0);
    drain();

    // General point
    send(3'b110, 3'b011, 3'b010);
    wait_out();
    check("gen_x", out_x, 3'b011);
    check("gen_y", out_y, 3'b010);
    check("gen_inf", out_inf, 0);
    drain();

    // Point at infinity
    send(3'b101, 3'b011, 3'b000);
    wait_out();
    check("inf_cycles", cyc - acc_at, 6);
    check("inf_x", out_x, 0);
    check("inf_y", out_y, 0);
    check("inf_flag", out_inf, 1);
    drain();

    // Backpressure with an ignored input pulse
    out_ready = 1'b0;
    send(3'b011, 3'b101, 3'b110);
    wait_out();
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2);
      in_x = 3'b111; in_y = 3'b111; in_z = 3'b111;
      check("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp_still_valid", out_valid, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_released_valid", out_valid, 0);
    check("bp_released_in_ready", in_ready, 1);
    check("bp_queue", q.size(), 0);

    // Reset during conversion
    send(3'b101, 3'b110, 3'b011);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_x", out_x, 0);
    check("midrst_out_y", out_y, 0);
    check("midrst_out_inf", out_inf, 0);
    check("midrst_in_ready", in_ready, 0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_in_ready_after", in_ready, 1);
    repeat (10) @(posedge clk);
    #1;
    check("midrst_no_output", q.size(), 0);

    // Stream of all nonzero Z, checking 2N+2 spacing between acceptances
    last_acc = 0;
    for (int z = 1; z < 8; z++) begin
      send(3'b110, 3'b001, N'(z));
      if (z > 1) check("stream_spacing", acc_at - last_acc, 2 * N + 2);
      last_acc = acc_at;
    end
    drain();

    // Randomized points with random gaps and random backpressure
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          send(N'($urandom), N'($urandom), N'($urandom));
        end
        drain();
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          out_ready = ($urandom_range(0, 2) != 0);
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
